// File: rtl/systemizer_pkg.sv
// Shared definitions for the GF(2) systolic systemizer.
//   op_e          : array op codes carried alongside the serial bit stream
//   pack_state_e  : row collector packing FSM states
//   words_per_row : number of WIDTH-bit words a ROW_LEN-bit row occupies
package systemizer_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_LOAD = 2'b01,
    OP_XOR  = 2'b10
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } pack_state_e;

  function automatic int words_per_row(input int row_len, input int width);
    return (row_len + width - 1) / width;
  endfunction

endpackage

// File: rtl/systemizer_collect_fifo.sv
// Synchronous FIFO buffering packed row words for the row collector.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write request and data (ignored when full unless popping)
//   pop/dout   : read request and head data (dout is zero while empty)
//   full/empty : occupancy flags, count : current occupancy
module systemizer_collect_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systemizer_row_collector.sv
// Output-side row collector: packs the serial row bit stream from the last
// processor column into WIDTH-bit words (first bit at LSB) and buffers them
// for the matrix memory. The array cannot stall, so a full buffer drops the
// word and raises the sticky overflow flag.
//   clk, rst_n                      : clock, async active-low reset
//   en_in, data_in, start_in, op_in : serial bit stream from the array
//   word_out/word_last/word_valid   : FIFO head, word_ready accepts it
//   fill                            : FIFO occupancy
//   overflow, short_row             : sticky error flags
// Optional feature macro SYSTEMIZER_COLLECT_OP_TAG_EN adds word_op, the op
// code sampled with bit 0 of the row, repeated on each word of that row.
module systemizer_row_collector
  import systemizer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ROW_LEN = 64,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_in,
  input  logic                   data_in,
  input  logic                   start_in,
  input  logic [1:0]             op_in,
  output logic [WIDTH-1:0]       word_out,
  output logic                   word_last,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
  output logic [1:0]             word_op,
`endif
  output logic                   short_row
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(ROW_LEN + 1);

  typedef struct packed {
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
    op_e              op;
`endif
    logic             last;
    logic [WIDTH-1:0] word;
  } entry_t;

  pack_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bcnt;
  logic [RW-1:0]    rcnt;
  logic             push_q;
  entry_t           push_d;
  entry_t           head;
  logic             fifo_full, fifo_empty, pop;

`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
  op_e              row_op;
`else
  logic             unused_op;
  assign unused_op = ^op_in;
`endif

  // Next-word arithmetic; a start bit always begins from an empty word.
  logic [WIDTH-1:0] base_w, nxt_w;
  logic [BW-1:0]    base_b, nxt_b;
  logic [RW-1:0]    base_r, nxt_r;
  logic             take, row_end, word_done, early;

  always_comb begin
    base_w    = start_in ? '0 : shreg;
    base_b    = start_in ? '0 : bcnt;
    base_r    = start_in ? '0 : rcnt;
    nxt_w     = base_w | (WIDTH'(data_in) << base_b);
    nxt_b     = base_b + BW'(1);
    nxt_r     = base_r + RW'(1);
    row_end   = (nxt_r == RW'(ROW_LEN));
    word_done = (nxt_b == BW'(WIDTH)) | row_end;
    take      = en_in & ((state == COLLECT) | start_in);
    // Only a non-empty partial word needs flushing on an early start.
    early     = en_in & start_in & (state == COLLECT) & (bcnt != '0);
  end

  assign pop = ~fifo_empty & word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      push_q    <= 1'b0;
      push_d    <= '0;
      overflow  <= 1'b0;
      short_row <= 1'b0;
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
      row_op    <= OP_PASS;
`endif
    end else begin
      push_q <= 1'b0;
      if (take) begin
        // One push slot per cycle: a flushed short row wins over a word that
        // the start bit itself would complete (only possible at WIDTH==1).
        if (early) begin
          push_q      <= 1'b1;
          push_d.last <= 1'b1;
          push_d.word <= shreg;
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
          push_d.op   <= row_op;
`endif
        end else if (word_done) begin
          push_q      <= 1'b1;
          push_d.last <= row_end;
          push_d.word <= nxt_w;
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
          push_d.op   <= start_in ? op_e'(op_in) : row_op;
`endif
        end
        if (start_in && state == COLLECT) short_row <= 1'b1;
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
        if (start_in) row_op <= op_e'(op_in);
`endif
        shreg <= word_done ? '0 : nxt_w;
        bcnt  <= word_done ? '0 : nxt_b;
        rcnt  <= row_end ? '0 : nxt_r;
        state <= row_end ? IDLE : COLLECT;
      end
      if (push_q && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  systemizer_collect_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (push_d),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill)
  );

  assign word_valid = ~fifo_empty;
  assign word_out   = head.word;
  assign word_last  = head.last;
`ifdef SYSTEMIZER_COLLECT_OP_TAG_EN
  assign word_op    = head.op;
`endif

endmodule
